debugger_cmd_sequencer: RTL and testbench

Controller for the debugger line-input block. It requests a line over the REQ_n/ACK_n handshake, then releases it. It parses the captured text as a read ("R aaaa") or write ("W aaaa dd") command. It then drives a single-beat memory access and presents the result or an error code to the debugger output side before requesting the next line.

---
 rtl/debugger_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_debugger_cmd_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_cmd_sequencer.sv
// Debugger command sequencer: fetches a line from the line-input block, parses
// "R aaaa" / "W aaaa dd", runs one memory access and presents the result.
module debugger_cmd_sequencer #(
    parameter int COUNT     = 64,
    parameter int ADDR_BITS = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    output logic                       LINE_REQ_n,
    input  logic                       LINE_ACK_n,
    input  logic                       LINE_DONE,
    input  logic [COUNT-1:0][7:0]      LINE_DATA,
    input  logic [$clog2(COUNT+1):0]   LINE_LENGTH,
    output logic                       MEM_REQ,
    output logic                       MEM_WE,
    output logic [ADDR_BITS-1:0]       MEM_ADDR,
    output logic [7:0]                 MEM_WDATA,
    input  logic                       MEM_ACK,
    input  logic [7:0]                 MEM_RDATA,
    output logic                       RESULT_VALID,
    output logic [7:0]                 RESULT_DATA,
    output logic [1:0]                 RESULT_ERR,
    input  logic                       RESULT_TAKEN
);
    localparam int LW   = $clog2(COUNT+1) + 1;
    localparam int IW   = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int TW   = $clog2(TIMEOUT+1);
    localparam int MAXD = (ADDR_BITS/4 < 4) ? ADDR_BITS/4 : 4;
    localparam logic [7:0] SP = 8'h20;

    typedef enum logic [2:0] {S_REQ, S_REL, S_PARSE, S_MEM, S_RESULT} state_t;
    typedef enum logic [2:0] {P_CMD, P_SP1, P_ADDR, P_SP2, P_DAT, P_TAIL} phase_t;

    state_t               state, state_n;
    phase_t               ph, ph_n;
    logic [LW-1:0]        len, idx;
    logic [1:0]           err, err_n, fin_err;
    logic [ADDR_BITS-1:0] addr, addr_n;
    logic [2:0]           ndig, ndig_n;
    logic [7:0]           wd, wd_n;
    logic [1:0]           ndd, ndd_n;
    logic                 wr, wr_n;
    logic [TW-1:0]        tcnt;
    logic [7:0]           ch;
    logic [3:0]           nib;
    logic                 is_hex, parse_end, fin_empty;

    logic                 line_req_n_d, mem_req_d, mem_we_d, res_valid_d;
    logic [ADDR_BITS-1:0] mem_addr_d;
    logic [7:0]           mem_wdata_d, res_data_d;
    logic [1:0]           res_err_d;

    assign ch        = LINE_DATA[idx[IW-1:0]];
    assign parse_end = (idx == len);

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39)      nib = 4'(ch - 8'h30);
        else if (ch >= 8'h41 && ch <= 8'h46) nib = 4'(ch - 8'h37);
        else if (ch >= 8'h61 && ch <= 8'h66) nib = 4'(ch - 8'h57);
        else                                 is_hex = 1'b0;
    end

    // One character step; once err is set the remaining characters are skipped.
    always_comb begin
        ph_n = ph; err_n = err; addr_n = addr; ndig_n = ndig;
        wd_n = wd; ndd_n = ndd; wr_n = wr;
        if (err == 2'd0) begin
            case (ph)
                P_CMD: begin
                    if (ch == 8'h52 || ch == 8'h72)      begin wr_n = 1'b0; ph_n = P_SP1; end
                    else if (ch == 8'h57 || ch == 8'h77) begin wr_n = 1'b1; ph_n = P_SP1; end
                    else if (ch != SP)                   err_n = 2'd1;
                end
                P_SP1: begin
                    if (ch == SP) ph_n = P_ADDR;
                    else          err_n = 2'd2;
                end
                P_ADDR: begin
                    if (is_hex) begin
                        if (ndig == 3'(MAXD)) err_n = 2'd2;
                        else begin
                            addr_n = ADDR_BITS'({addr, nib});
                            ndig_n = ndig + 3'd1;
                        end
                    end else if (ch == SP) begin
                        if (ndig != 3'd0) ph_n = wr ? P_SP2 : P_TAIL;
                    end else err_n = 2'd2;
                end
                P_SP2: begin
                    if (is_hex) begin wd_n = {4'h0, nib}; ndd_n = 2'd1; ph_n = P_DAT; end
                    else if (ch != SP) err_n = 2'd2;
                end
                P_DAT: begin
                    if (is_hex) begin
                        if (ndd == 2'd2) err_n = 2'd2;
                        else begin wd_n = {wd[3:0], nib}; ndd_n = 2'd2; end
                    end else if (ch == SP) ph_n = P_TAIL;
                    else err_n = 2'd2;
                end
                default: if (ch != SP) err_n = 2'd2;
            endcase
        end
    end

    // End-of-line verdict: a blank line produces nothing; missing fields are syntax errors.
    always_comb begin
        fin_empty = (err == 2'd0) && (ph == P_CMD);
        if (err != 2'd0) fin_err = err;
        else if (ph == P_SP1 || (ph == P_ADDR && ndig == 3'd0) ||
                 (wr && (ph == P_ADDR || ph == P_SP2)))
            fin_err = 2'd2;
        else fin_err = 2'd0;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state <= S_REQ;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_REQ:    if (!LINE_ACK_n && LINE_DONE) state_n = S_REL;
            S_REL:    if (LINE_ACK_n) state_n = S_PARSE;
            S_PARSE:  if (parse_end)
                          state_n = fin_empty ? S_REQ : ((fin_err != 2'd0) ? S_RESULT : S_MEM);
            S_MEM:    if (MEM_ACK || tcnt == TW'(TIMEOUT-1)) state_n = S_RESULT;
            S_RESULT: if (RESULT_TAKEN) state_n = S_REQ;
            default:  state_n = S_REQ;
        endcase
    end

    always_comb begin
        line_req_n_d = (state_n != S_REQ);
        mem_req_d    = MEM_REQ;
        mem_we_d     = MEM_WE;
        mem_addr_d   = MEM_ADDR;
        mem_wdata_d  = MEM_WDATA;
        res_valid_d  = RESULT_VALID;
        res_data_d   = RESULT_DATA;
        res_err_d    = RESULT_ERR;
        case (state)
            S_PARSE: begin
                if (parse_end && state_n == S_MEM) begin
                    mem_req_d = 1'b1; mem_we_d = wr; mem_addr_d = addr; mem_wdata_d = wd;
                end else if (parse_end && state_n == S_RESULT) begin
                    res_valid_d = 1'b1; res_data_d = 8'h00; res_err_d = fin_err;
                end
            end
            S_MEM: begin
                if (state_n == S_RESULT) begin
                    mem_req_d   = 1'b0;
                    res_valid_d = 1'b1;
                    res_data_d  = MEM_ACK ? (MEM_WE ? MEM_WDATA : MEM_RDATA) : 8'h00;
                    res_err_d   = MEM_ACK ? 2'd0 : 2'd3;
                end
            end
            S_RESULT: if (RESULT_TAKEN) res_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            LINE_REQ_n <= 1'b1;
            MEM_REQ <= 1'b0; MEM_WE <= 1'b0; MEM_ADDR <= '0; MEM_WDATA <= 8'h00;
            RESULT_VALID <= 1'b0; RESULT_DATA <= 8'h00; RESULT_ERR <= 2'd0;
        end else begin
            LINE_REQ_n <= line_req_n_d;
            MEM_REQ <= mem_req_d; MEM_WE <= mem_we_d; MEM_ADDR <= mem_addr_d; MEM_WDATA <= mem_wdata_d;
            RESULT_VALID <= res_valid_d; RESULT_DATA <= res_data_d; RESULT_ERR <= res_err_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            len <= '0; idx <= '0; ph <= P_CMD; err <= 2'd0; addr <= '0;
            ndig <= 3'd0; wd <= 8'h00; ndd <= 2'd0; wr <= 1'b0; tcnt <= '0;
        end else begin
            if (state == S_REQ && state_n == S_REL) len <= LINE_LENGTH;
            if (state == S_REL) begin
                idx <= '0; ph <= P_CMD; err <= 2'd0; addr <= '0;
                ndig <= 3'd0; wd <= 8'h00; ndd <= 2'd0; wr <= 1'b0;
            end
            if (state == S_PARSE && !parse_end) begin
                idx <= idx + 1'b1; ph <= ph_n; err <= err_n; addr <= addr_n;
                ndig <= ndig_n; wd <= wd_n; ndd <= ndd_n; wr <= wr_n;
            end
            tcnt <= (state == S_MEM) ? tcnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_debugger_cmd_sequencer.sv
// Scoreboard bench for debugger_cmd_sequencer: directed lines, a memory
// responder and a result monitor checking against queued expectations.
module tb_debugger_cmd_sequencer;
    localparam int COUNT = 64, ADDR_BITS = 16, TIMEOUT = 255;

    logic                     CLK = 1'b0;
    logic                     RESET_n;
    logic                     LINE_REQ_n, LINE_ACK_n, LINE_DONE;
    logic [COUNT-1:0][7:0]    LINE_DATA;
    logic [7:0]               LINE_LENGTH;
    logic                     MEM_REQ, MEM_WE, MEM_ACK;
    logic [ADDR_BITS-1:0]     MEM_ADDR;
    logic [7:0]               MEM_WDATA, MEM_RDATA;
    logic                     RESULT_VALID, RESULT_TAKEN;
    logic [7:0]               RESULT_DATA;
    logic [1:0]               RESULT_ERR;

    debugger_cmd_sequencer #(.COUNT(COUNT), .ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .LINE_REQ_n(LINE_REQ_n), .LINE_ACK_n(LINE_ACK_n), .LINE_DONE(LINE_DONE),
        .LINE_DATA(LINE_DATA), .LINE_LENGTH(LINE_LENGTH),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .RESULT_VALID(RESULT_VALID), .RESULT_DATA(RESULT_DATA), .RESULT_ERR(RESULT_ERR),
        .RESULT_TAKEN(RESULT_TAKEN)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; logic [7:0] rdata; int delay; } mem_t;
    typedef struct { logic [7:0] data; logic [1:0] err; bit chk_data; } res_t;

    mem_t mem_q[$];
    res_t res_q[$];
    int   checks = 0, failures = 0;
    int   n_memreq = 0, n_result = 0;
    bit   hold_taken = 1'b0, mem_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk(name, {LINE_REQ_n, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RESULT_VALID, RESULT_DATA, RESULT_ERR},
            {1'b1, 37'b0});
    endtask

    // Memory responder: checks each request against the queue, acks after 'delay'
    // cycles; delay<0 never acks and expects the request to drop after TIMEOUT cycles.
    initial begin
        mem_t cur;
        int cnt, reqc;
        MEM_ACK = 1'b0; MEM_RDATA = 8'h00; cnt = 0; reqc = 0;
        cur = '{1'b0, 16'h0, 8'h0, 8'h0, -1};
        forever begin
            @(negedge CLK);
            if (!RESET_n) begin
                mem_busy = 1'b0; MEM_ACK = 1'b0;
            end else if (!mem_busy) begin
                if (MEM_REQ) begin
                    n_memreq++;
                    chk("mem_expected", 64'(mem_q.size() != 0), 1);
                    if (mem_q.size() != 0) begin
                        cur = mem_q.pop_front();
                        chk("mem_we", MEM_WE, cur.we);
                        chk("mem_addr", MEM_ADDR, cur.addr);
                        if (cur.we) chk("mem_wdata", MEM_WDATA, cur.wdata);
                    end else cur = '{1'b0, 16'h0, 8'h0, 8'h0, -1};
                    mem_busy = 1'b1; cnt = 0; reqc = 1;
                    if (cur.delay == 0) begin MEM_ACK = 1'b1; MEM_RDATA = cur.rdata; end
                end
            end else if (!MEM_REQ) begin
                MEM_ACK = 1'b0; mem_busy = 1'b0;
                if (cur.delay < 0) chk("timeout_req_cycles", reqc, TIMEOUT);
            end else begin
                MEM_ACK = 1'b0; reqc++; cnt++;
                if (cnt == cur.delay) begin MEM_ACK = 1'b1; MEM_RDATA = cur.rdata; end
            end
        end
    end

    // Result monitor: compares each new result once, then accepts it unless held.
    initial begin
        res_t e;
        bit seen;
        RESULT_TAKEN = 1'b0; seen = 1'b0;
        forever begin
            @(negedge CLK);
            RESULT_TAKEN = 1'b0;
            if (!RESET_n) seen = 1'b0;
            else if (RESULT_VALID) begin
                if (!seen) begin
                    seen = 1'b1; n_result++;
                    chk("result_expected", 64'(res_q.size() != 0), 1);
                    if (res_q.size() != 0) begin
                        e = res_q.pop_front();
                        chk("result_err", RESULT_ERR, e.err);
                        if (e.chk_data) chk("result_data", RESULT_DATA, e.data);
                    end
                end
                if (!hold_taken) begin RESULT_TAKEN = 1'b1; seen = 1'b0; end
            end
        end
    end

    task automatic send_line(input string s);
        int i;
        LINE_DATA = '0;
        for (int k = 0; k < s.len(); k++) LINE_DATA[k] = s[k];
        LINE_LENGTH = 8'(s.len());
        for (i = 0; i < 600; i++) begin @(negedge CLK); if (!LINE_REQ_n) break; end
        chk("line_req_low", 64'(i < 600), 1);
        LINE_ACK_n = 1'b0; LINE_DONE = 1'b1;
        for (i = 0; i < 20; i++) begin @(negedge CLK); if (LINE_REQ_n) break; end
        chk("line_req_release", 64'(i < 20), 1);
        LINE_ACK_n = 1'b1; LINE_DONE = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK); #1;
            if (!LINE_REQ_n && !RESULT_VALID && !mem_busy && res_q.size() == 0 && mem_q.size() == 0) break;
        end
        chk({name, "_idle"}, 64'(i < budget), 1);
    endtask

    task automatic run_err(input string s, input logic [1:0] err);
        int m0;
        m0 = n_memreq;
        res_q.push_back('{8'h00, err, 1'b0});
        send_line(s);
        wait_idle(s, 200);
        chk({s, "_no_memreq"}, n_memreq, m0);
    endtask

    task automatic run_blank(input string s);
        int m0, r0;
        m0 = n_memreq; r0 = n_result;
        send_line(s);
        wait_idle("blank", 100);
        chk("blank_no_memreq", n_memreq, m0);
        chk("blank_no_result", n_result, r0);
        chk("blank_req_low", LINE_REQ_n, 1'b0);
    endtask

    task automatic reset_pulse(input string name);
        #2 RESET_n = 1'b0;
        #1 chk_reset(name);
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        #1 chk({name, "_req_hold"}, LINE_REQ_n, 1'b1);
        @(posedge CLK); #1 chk({name, "_req_after"}, LINE_REQ_n, 1'b0);
    endtask

    initial begin
        string s;
        int lat, i;
        RESET_n = 1'b0; LINE_ACK_n = 1'b1; LINE_DONE = 1'b0; LINE_DATA = '0; LINE_LENGTH = 8'd0;
        #12 chk_reset("reset_state");
        @(negedge CLK) RESET_n = 1'b1;
        #1 chk("req_after_rst_hold", LINE_REQ_n, 1'b1);
        @(posedge CLK); #1 chk("req_after_rst", LINE_REQ_n, 1'b0);

        // "R 1234": release sampled on the first edge, then len+1 cycles to MEM_REQ.
        mem_q.push_back('{1'b0, 16'h1234, 8'h00, 8'hA5, 3});
        res_q.push_back('{8'hA5, 2'd0, 1'b1});
        send_line("R 1234");
        lat = 0;
        for (i = 0; i < 100; i++) begin @(posedge CLK); #1; lat++; if (MEM_REQ) break; end
        chk("latency_R1234", lat, 6 + 2);
        wait_idle("R1234", 100);

        mem_q.push_back('{1'b1, 16'h00FF, 8'h3C, 8'h77, 1});
        res_q.push_back('{8'h3C, 2'd0, 1'b1});
        send_line("  w 00ff 3c  ");
        wait_idle("w00ff", 100);

        mem_q.push_back('{1'b0, 16'hABCD, 8'h00, 8'h5A, 0});
        res_q.push_back('{8'h5A, 2'd0, 1'b1});
        send_line("r ABCD");
        wait_idle("rABCD", 100);

        run_err("X 12", 2'd1);
        run_err("R 12345", 2'd2);
        run_err("W 10", 2'd2);
        run_err("R 1G", 2'd2);
        run_err("Rx 1", 2'd2);
        run_err("R", 2'd2);

        run_blank("");
        run_blank("   ");

        // Full-length line: len == COUNT must still parse.
        s = "R 12";
        while (s.len() < COUNT) s = {s, " "};
        mem_q.push_back('{1'b0, 16'h0012, 8'h00, 8'h11, 2});
        res_q.push_back('{8'h11, 2'd0, 1'b1});
        send_line(s);
        wait_idle("len64", 200);

        mem_q.push_back('{1'b0, 16'h0010, 8'h00, 8'h00, -1});
        res_q.push_back('{8'h00, 2'd3, 1'b1});
        send_line("R 0010");
        wait_idle("timeout", 400);

        // Reset while a memory access is outstanding.
        mem_q.push_back('{1'b0, 16'h0010, 8'h00, 8'h00, -1});
        send_line("R 0010");
        for (i = 0; i < 50; i++) begin @(negedge CLK); if (MEM_REQ) break; end
        chk("rst_mem_reached", 64'(i < 50), 1);
        repeat (4) @(negedge CLK);
        reset_pulse("rst_in_mem");

        // Reset while a result is being presented.
        hold_taken = 1'b1;
        res_q.push_back('{8'h00, 2'd1, 1'b0});
        send_line("X 12");
        for (i = 0; i < 50; i++) begin @(negedge CLK); if (RESULT_VALID) break; end
        chk("rst_res_reached", 64'(i < 50), 1);
        repeat (3) @(negedge CLK);
        reset_pulse("rst_in_result");
        hold_taken = 1'b0;

        mem_q.push_back('{1'b1, 16'h0001, 8'h07, 8'hEE, 2});
        res_q.push_back('{8'h07, 2'd0, 1'b1});
        send_line("W 1 7");
        wait_idle("W1_7", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
